bcd_converter: RTL and testbench

BCD_CONVERTER -- requirements
Module: bcd_converter

---
 rtl/bcd_converter.sv | 157 +++++++++++++++
 tb/tb_bcd_converter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_converter.sv
// ---------------------------------------------------------------------------
// bcd_converter
//
// Purpose:
//   Sequential binary-to-BCD converter using the double-dabble (shift-add-3)
//   algorithm.  One input bit is consumed per SHIFT cycle, so a conversion
//   takes IN_W SHIFT cycles plus one DONE cycle.  The lower four decimal
//   digits are presented on bcd; a fifth scratch digit flags values above
//   9999 on ovf.  All outputs are driven straight from flops.
//
// Ports:
//   clk    in   1     system clock, rising-edge active
//   reset  in   1     synchronous, active-high reset
//   start  in   1     conversion request, honoured only when idle
//   bin    in   IN_W  unsigned value, captured when start is accepted
//   busy   out  1     conversion in progress (SHIFT or DONE)
//   done   out  1     one-cycle pulse when bcd/ovf update
//   bcd    out  16    packed BCD, [15:12] thousands ... [3:0] units
//   ovf    out  1     last converted value was above 9999
//   valid  out  1     at least one conversion has completed since reset
// ---------------------------------------------------------------------------
module bcd_converter #(
   parameter int IN_W = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [IN_W-1:0] bin,
   output logic            busy,
   output logic            done,
   output logic [15:0]     bcd,
   output logic            ovf,
   output logic            valid
);

   localparam int CNT_W  = $clog2(IN_W + 1);
   localparam int SCR_W  = 20;               // five BCD digits
   localparam int CAT_W  = SCR_W + IN_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IN_W-1:0]    bin_q, bin_d;
   logic [SCR_W-1:0]   scratch_q, scratch_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [15:0]        bcd_q, bcd_d;
   logic               ovf_q, ovf_d;
   logic               valid_q, valid_d;

   logic [SCR_W-1:0]   adj;
   logic [CAT_W-1:0]   shifted;

   // Add 3 to every digit that is 5 or more, so the following left shift
   // carries correctly into the next decimal digit.
   function automatic logic [SCR_W-1:0] add3(input logic [SCR_W-1:0] s);
      logic [SCR_W-1:0] r;
      r = s;
      for (int i = 0; i < SCR_W / 4; i++) begin
         if (s[i*4 +: 4] >= 4'd5) begin
            r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   // Next-state and datapath logic.
   // NOTE: every signal written here gets a default first, so no path through
   // the case statement leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      valid_d   = valid_q;
      adj       = add3(scratch_q);
      shifted   = {adj, bin_q} << 1;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               bin_d     = bin;
               scratch_d = '0;
               cnt_d     = CNT_W'(IN_W);
               state_d   = SHIFT;
            end
         end

         SHIFT: begin
            scratch_d = shifted[CAT_W-1 -: SCR_W];
            bin_d     = shifted[IN_W-1:0];
            cnt_d     = cnt_q - CNT_W'(1);
            // Last input bit: publish the finished scratch value so bcd,
            // ovf and valid change together with the done pulse.
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               bcd_d   = scratch_d[15:0];
               ovf_d   = (scratch_d[19:16] != 4'd0);
               valid_d = 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Status flags are derived from the next state so they come out of
      // flops aligned with the state register.
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // NOTE: non-blocking assignments for all state so every flop samples the
   // values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         bin_q     <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bcd_q     <= 16'h0000;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
         valid_q   <= valid_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign bcd   = bcd_q;
   assign ovf   = ovf_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_bcd_converter.sv
// ---------------------------------------------------------------------------
// tb_bcd_converter
//
// Purpose:
//   Self-checking bench for bcd_converter (IN_W = 16).  A reference process
//   mirrors the externally visible contract (accept start only when idle,
//   result after 17 cycles, reset aborts) and pushes the decimally computed
//   result into a scoreboard queue on every accepted start.  A monitor pops
//   an entry whenever the DUT pulses done and checks the outputs every cycle.
// ---------------------------------------------------------------------------
module tb_bcd_converter;

   localparam int IN_W    = 16;
   localparam int LATENCY = IN_W + 1;   // cycles from accept to done

   logic            clk;
   logic            reset;
   logic            start;
   logic [IN_W-1:0] bin;
   logic            busy;
   logic            done;
   logic [15:0]     bcd;
   logic            ovf;
   logic            valid;

   bcd_converter #(.IN_W(IN_W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .ovf   (ovf),
      .valid (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bcd;
      logic        ovf;
      int unsigned value;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   model_rem = 0;   // cycles of busy left after the last edge
   bit   mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Decimal reference: lower four digits plus overflow flag.
   function automatic exp_t ref_model(input int unsigned v);
      exp_t        e;
      int unsigned d;
      d     = v % 10000;
      e.bcd = {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
      e.ovf = (v > 9999);
      e.value = v;
      return e;
   endfunction

   // Reference of the handshake: start is taken only when no conversion is
   // outstanding; reset discards anything in flight.
   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            model_rem = 0;
            sb_q.delete();
         end else if (model_rem != 0) begin
            model_rem = model_rem - 1;
         end else if (start) begin
            sb_q.push_back(ref_model(int'(bin)));
            model_rem = LATENCY;
         end
      end
   end

   // Monitor: checks outputs 1 time unit after each rising edge.
   initial begin
      logic [15:0] h_bcd;
      logic        h_ovf;
      logic        h_valid;
      exp_t        e;
      logic        nib_ok;
      h_bcd = '0; h_ovf = 1'b0; h_valid = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            mon_en  = 1'b1;
            h_bcd   = 16'h0000;
            h_ovf   = 1'b0;
            h_valid = 1'b0;
         end else if (mon_en && done) begin
            if (sb_q.size() == 0) begin
               check("done_without_request", 32'(done), 32'd0);
            end else begin
               e       = sb_q.pop_front();
               h_bcd   = e.bcd;
               h_ovf   = e.ovf;
               h_valid = 1'b1;
               check("result_bcd", 32'(bcd), 32'(e.bcd));
               check("result_ovf", 32'(ovf), 32'(e.ovf));
            end
         end
         if (mon_en) begin
            check("busy",  32'(busy),  32'(model_rem != 0));
            check("done",  32'(done),  32'(model_rem == 1));
            check("bcd",   32'(bcd),   32'(h_bcd));
            check("ovf",   32'(ovf),   32'(h_ovf));
            check("valid", 32'(valid), 32'(h_valid));
            nib_ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
               if (bcd[i*4 +: 4] > 4'd9) nib_ok = 1'b0;
            end
            check("bcd_digits_legal", 32'(nib_ok), 32'd1);
         end
      end
   end

   // Issue a one-cycle start pulse; called and returns on a falling edge.
   task automatic pulse(input logic [IN_W-1:0] v);
      start = 1'b1;
      bin   = v;
      @(negedge clk);
      start = 1'b0;
      bin   = IN_W'($urandom);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Watchdog: the bench must never hang.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [IN_W-1:0] directed [6];
      directed[0] = 16'd1234;
      directed[1] = 16'd9999;
      directed[2] = 16'd65535;
      directed[3] = 16'd10000;
      directed[4] = 16'd4095;
      directed[5] = 16'd10;

      reset = 1'b1;
      start = 1'b0;
      bin   = '0;
      wait_cycles(3);

      // Release reset and request 0 in the same cycle: must be accepted.
      reset = 1'b0;
      pulse(16'd0);
      wait_cycles(LATENCY + 1);

      foreach (directed[i]) begin
         pulse(directed[i]);
         wait_cycles(LATENCY + 1);
      end

      // Start pulse during a conversion must be ignored.
      pulse(16'd42);
      wait_cycles(3);
      pulse(16'd777);
      wait_cycles(LATENCY);

      // Reset in the middle of a conversion, then redo it.
      pulse(16'd500);
      wait_cycles(6);
      reset = 1'b1;
      wait_cycles(1);
      reset = 1'b0;
      wait_cycles(4);
      pulse(16'd500);
      wait_cycles(LATENCY + 1);

      // Random start/bin activity, including requests while busy.
      for (int i = 0; i < 3000; i++) begin
         start = ($urandom_range(0, 3) == 0);
         bin   = IN_W'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      wait_cycles(LATENCY + 2);

      // Back-to-back: start held high, bin stepped once per accepted request.
      start = 1'b1;
      for (int v = 0; v <= 9999; v += 7) begin
         bin = IN_W'(v);
         wait_cycles(LATENCY + 1);
      end
      bin = 16'd9999;
      wait_cycles(LATENCY + 1);
      start = 1'b0;

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
